// File: rtl/cpu_irq_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_irq_sequencer_if
//   Memory-bus and start/done handshake bundle between the CPU executor and
//   the interrupt/return sequencer.
//
//   mem_addr      16  bus address driven by the sequencer while busy=1
//   mem_data_in    8  read data from synchronous memory
//   mem_data_out   8  write data
//   mem_write_en   1  write strobe, one cycle per byte
//   start          1  one-cycle start pulse from the executor
//   done           1  result valid, held until the next start
//   busy           1  sequencer owns the memory bus
//
//   master : the sequencer side
//   slave  : the executor / memory side
// ---------------------------------------------------------------------------
interface cpu_irq_sequencer_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic        mem_write_en;
    logic        start;
    logic        done;
    logic        busy;

    modport master (
        output mem_addr,
        output mem_data_out,
        output mem_write_en,
        output done,
        output busy,
        input  mem_data_in,
        input  start
    );

    modport slave (
        input  mem_addr,
        input  mem_data_out,
        input  mem_write_en,
        input  done,
        input  busy,
        output mem_data_in,
        output start
    );
endinterface

// File: rtl/cpu_irq_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_irq_sequencer
//   6502-style interrupt/return sequencer run once after every instruction.
//   Services soft reset, RTI, BRK and PPU vblank NMI by driving the memory
//   bus itself; otherwise passes PC/P/SP straight through to the executor.
//
//   Optional feature macro: IRQ_PPU_NMI_EN
//     defined   : a ppu_status[7] rising edge latches a pending NMI
//     undefined : ppu_status is ignored and no NMI is ever taken
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     bus (master)      mem_addr/mem_data_in/mem_data_out/mem_write_en,
//                       start/done/busy handshake
//     is_break, is_rti  current instruction is BRK / RTI
//     soft_reset        soft-reset request (level)
//     ppu_status        PPU status, bit7 = vblank
//     pc_in/status_in/stack_in     executor PC, P and SP
//     pc_out/status_out/stack_out  resulting PC, P and SP
//     interrupt_disable status_out[2]
//     halt              freezes every register, outputs hold
// ---------------------------------------------------------------------------
module cpu_irq_sequencer #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] BRK_VEC = 16'hFFFE
) (
    input  logic                clk,
    input  logic                rst,
    cpu_irq_sequencer_if.master bus,
    input  logic                is_break,
    input  logic [7:0]          ppu_status,
    input  logic                soft_reset,
    input  logic                is_rti,
    input  logic [15:0]         pc_in,
    input  logic [7:0]          status_in,
    input  logic [7:0]          stack_in,
    output logic [15:0]         pc_out,
    output logic [7:0]          status_out,
    output logic [7:0]          stack_out,
    output logic                interrupt_disable,
    input  logic                halt
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_PASS    = 4'd1;
    localparam logic [3:0] S_PUSH_H  = 4'd2;
    localparam logic [3:0] S_PUSH_L  = 4'd3;
    localparam logic [3:0] S_PUSH_P  = 4'd4;
    localparam logic [3:0] S_VEC_LO  = 4'd5;
    localparam logic [3:0] S_VEC_HI  = 4'd6;
    localparam logic [3:0] S_VEC_W   = 4'd7;
    localparam logic [3:0] S_VEC_FIN = 4'd8;
    localparam logic [3:0] S_RTI_1   = 4'd9;
    localparam logic [3:0] S_RTI_2   = 4'd10;
    localparam logic [3:0] S_RTI_3   = 4'd11;
    localparam logic [3:0] S_RTI_W   = 4'd12;
    localparam logic [3:0] S_RTI_FIN = 4'd13;

    logic [3:0]  state;
    logic [15:0] pc_q;
    logic [7:0]  p_q;
    logic [7:0]  sp_q;
    logic [15:0] vec_q;
    logic [7:0]  lo_q;
    logic [7:0]  rti_p_q;
    logic        is_nmi_q;
    logic        rst_pend;
    logic        nmi_pend;
    logic        nmi_edge;

    logic        rst_req;
    logic        nmi_req;
    logic        take;
    logic        sel_rst;
    logic        sel_rti;
    logic        sel_brk;
    logic        sel_nmi;
    logic [7:0]  sp_inc;
    logic [7:0]  sp_dec;

    // Status byte as stacked: BRK sets B and bit5, NMI sets bit5 and clears B.
    function automatic logic [7:0] push_status(input logic [7:0] p, input logic nmi);
        if (nmi)
            push_status = (p | 8'h20) & ~8'h10;
        else
            push_status = p | 8'h30;
    endfunction

    // A request arriving in the same cycle as start is serviced immediately.
    assign rst_req = rst_pend | soft_reset;
    assign nmi_req = nmi_pend | nmi_edge;

    assign take    = (state == S_IDLE) && bus.start;
    assign sel_rst = take && rst_req;
    assign sel_rti = take && !rst_req && is_rti;
    assign sel_brk = take && !rst_req && !is_rti && is_break;
    assign sel_nmi = take && !rst_req && !is_rti && !is_break && nmi_req;

    assign sp_inc = sp_q + 8'd1;
    assign sp_dec = sp_q - 8'd1;

    assign interrupt_disable = status_out[2];

`ifdef IRQ_PPU_NMI_EN
    logic ppu_vbl_prev;
    logic unused_ppu_bits;

    assign nmi_edge        = ppu_status[7] & ~ppu_vbl_prev;
    assign unused_ppu_bits = ^ppu_status[6:0];

    // Edge history holds under halt so a vblank edge is never lost or doubled.
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_pend     <= 1'b0;
            ppu_vbl_prev <= 1'b0;
        end else if (!halt) begin
            nmi_pend     <= sel_nmi ? 1'b0 : nmi_req;
            ppu_vbl_prev <= ppu_status[7];
        end
    end
`else
    logic unused_ppu_bits;

    assign nmi_pend        = 1'b0;
    assign nmi_edge        = 1'b0;
    assign unused_ppu_bits = ^ppu_status;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            pc_q              <= '0;
            p_q               <= '0;
            sp_q              <= '0;
            vec_q             <= '0;
            lo_q              <= '0;
            rti_p_q           <= '0;
            is_nmi_q          <= 1'b0;
            rst_pend          <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_data_out  <= '0;
            bus.mem_write_en  <= 1'b0;
            bus.done          <= 1'b0;
            bus.busy          <= 1'b0;
            pc_out            <= '0;
            status_out        <= '0;
            stack_out         <= '0;
        end else if (!halt) begin
            rst_pend         <= sel_rst ? 1'b0 : rst_req;
            bus.mem_write_en <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        pc_q     <= pc_in;
                        p_q      <= status_in;
                        sp_q     <= stack_in;
                        vec_q    <= BRK_VEC;
                        is_nmi_q <= 1'b0;
                        bus.done <= 1'b0;
                        if (sel_rst) begin
                            // Soft reset skips the pushes but still moves SP as if it had pushed.
                            p_q   <= status_in | 8'h04;
                            sp_q  <= stack_in - 8'd3;
                            vec_q <= RST_VEC;
                            state <= S_VEC_LO;
                        end else if (sel_rti) begin
                            state <= S_RTI_1;
                        end else if (sel_brk) begin
                            state <= S_PUSH_H;
                        end else if (sel_nmi) begin
                            is_nmi_q <= 1'b1;
                            vec_q    <= NMI_VEC;
                            state    <= S_PUSH_H;
                        end else begin
                            state <= S_PASS;
                        end
                    end
                end

                S_PASS: begin
                    pc_out     <= pc_q;
                    status_out <= p_q;
                    stack_out  <= sp_q;
                    bus.done   <= 1'b1;
                    state      <= S_IDLE;
                end

                S_PUSH_H: begin
                    bus.busy         <= 1'b1;
                    bus.mem_addr     <= {8'h01, sp_q};
                    bus.mem_data_out <= pc_q[15:8];
                    bus.mem_write_en <= 1'b1;
                    sp_q             <= sp_dec;
                    state            <= S_PUSH_L;
                end

                S_PUSH_L: begin
                    bus.mem_addr     <= {8'h01, sp_q};
                    bus.mem_data_out <= pc_q[7:0];
                    bus.mem_write_en <= 1'b1;
                    sp_q             <= sp_dec;
                    state            <= S_PUSH_P;
                end

                S_PUSH_P: begin
                    bus.mem_addr     <= {8'h01, sp_q};
                    bus.mem_data_out <= push_status(p_q, is_nmi_q);
                    bus.mem_write_en <= 1'b1;
                    sp_q             <= sp_dec;
                    p_q              <= p_q | 8'h04;
                    state            <= S_VEC_LO;
                end

                S_VEC_LO: begin
                    bus.busy     <= 1'b1;
                    bus.mem_addr <= vec_q;
                    state        <= S_VEC_HI;
                end

                S_VEC_HI: begin
                    bus.mem_addr <= vec_q + 16'd1;
                    state        <= S_VEC_W;
                end

                // Memory returns data two edges after the address: low byte lands here.
                S_VEC_W: begin
                    lo_q  <= bus.mem_data_in;
                    state <= S_VEC_FIN;
                end

                S_VEC_FIN: begin
                    pc_out     <= {bus.mem_data_in, lo_q};
                    status_out <= p_q;
                    stack_out  <= sp_q;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= S_IDLE;
                end

                S_RTI_1: begin
                    bus.busy     <= 1'b1;
                    sp_q         <= sp_inc;
                    bus.mem_addr <= {8'h01, sp_inc};
                    state        <= S_RTI_2;
                end

                S_RTI_2: begin
                    sp_q         <= sp_inc;
                    bus.mem_addr <= {8'h01, sp_inc};
                    state        <= S_RTI_3;
                end

                // Third pull address goes out while the first pulled byte (P) arrives.
                S_RTI_3: begin
                    sp_q         <= sp_inc;
                    bus.mem_addr <= {8'h01, sp_inc};
                    rti_p_q      <= bus.mem_data_in & 8'hCF;
                    state        <= S_RTI_W;
                end

                S_RTI_W: begin
                    lo_q  <= bus.mem_data_in;
                    state <= S_RTI_FIN;
                end

                S_RTI_FIN: begin
                    pc_out     <= {bus.mem_data_in, lo_q};
                    status_out <= rti_p_q;
                    stack_out  <= sp_q;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_irq_sequencer.sv
module tb_cpu_irq_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_break;
    logic [7:0]  ppu_status;
    logic        soft_reset;
    logic        is_rti;
    logic [15:0] pc_in;
    logic [7:0]  status_in;
    logic [7:0]  stack_in;
    logic [15:0] pc_out;
    logic [7:0]  status_out;
    logic [7:0]  stack_out;
    logic        interrupt_disable;
    logic        halt;

    cpu_irq_sequencer_if bus ();

    cpu_irq_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .is_break          (is_break),
        .ppu_status        (ppu_status),
        .soft_reset        (soft_reset),
        .is_rti            (is_rti),
        .pc_in             (pc_in),
        .status_in         (status_in),
        .stack_in          (stack_in),
        .pc_out            (pc_out),
        .status_out        (status_out),
        .stack_out         (stack_out),
        .interrupt_disable (interrupt_disable),
        .halt              (halt)
    );

    always #5 clk = ~clk;

    // Synchronous memory: one-edge registered read, stalls together with the CPU on halt.
    logic [7:0]  mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!halt) begin
            if (bus.mem_write_en) begin
                mem[bus.mem_addr] <= bus.mem_data_out;
                wr_cnt <= wr_cnt + 1;
            end
            bus.mem_data_in <= mem[bus.mem_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int w0;
    logic busy_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!bus.done && c < 30) begin
            tick();
            busy_seen = busy_seen | bus.busy;
            c++;
        end
    endtask

    // Pulse start with the current inputs; returns edges from the start edge to done.
    task automatic run_start(output int c);
        busy_seen = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0; is_break = 1'b0; is_rti = 1'b0; soft_reset = 1'b0;
        busy_seen = bus.busy;
        chk("done_clear_at_start", 32'(bus.done), 'h0);
        wait_done(c);
    endtask

    task automatic set_cpu(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp);
        pc_in = pc; status_in = p; stack_in = sp;
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; is_break = 1'b0; is_rti = 1'b0; soft_reset = 1'b0;
        ppu_status = 8'h00; bus.start = 1'b0;
        set_cpu(16'h0000, 8'h00, 8'h00);
        tick(); tick();

        // Reset state
        chk("rst_done", 32'(bus.done), 'h0);
        chk("rst_busy", 32'(bus.busy), 'h0);
        chk("rst_addr", 32'(bus.mem_addr), 'h0);
        chk("rst_wen", 32'(bus.mem_write_en), 'h0);
        chk("rst_dout", 32'(bus.mem_data_out), 'h0);
        chk("rst_pc", 32'(pc_out), 'h0);
        chk("rst_p", 32'(status_out), 'h0);
        chk("rst_sp", 32'(stack_out), 'h0);
        chk("rst_idis", 32'(interrupt_disable), 'h0);
        rst = 1'b0;

        poke(16'hFFFE, 8'h00); poke(16'hFFFF, 8'h90);
        poke(16'hFFFC, 8'h00); poke(16'hFFFD, 8'h80);
        poke(16'hFFFA, 8'h00); poke(16'hFFFB, 8'hA0);
        poke(16'h01FD, 8'h00); poke(16'h01FC, 8'h00); poke(16'h01FB, 8'h00);

        // Pass-through
        set_cpu(16'hC123, 8'h24, 8'hFD);
        w0 = wr_cnt;
        run_start(cyc);
        chk("pass_lat", cyc, 1);
        chk("pass_busy", 32'(busy_seen), 'h0);
        chk("pass_pc", 32'(pc_out), 'hC123);
        chk("pass_p", 32'(status_out), 'h24);
        chk("pass_sp", 32'(stack_out), 'hFD);
        chk("pass_idis", 32'(interrupt_disable), 'h1);
        chk("pass_wr", wr_cnt - w0, 0);

        // BRK
        set_cpu(16'h8002, 8'h20, 8'hFD);
        is_break = 1'b1;
        w0 = wr_cnt;
        run_start(cyc);
        chk("brk_lat", cyc, 7);
        chk("brk_busy_drop", 32'(bus.busy), 'h0);
        chk("brk_pc", 32'(pc_out), 'h9000);
        chk("brk_p", 32'(status_out), 'h24);
        chk("brk_sp", 32'(stack_out), 'hFA);
        chk("brk_idis", 32'(interrupt_disable), 'h1);
        chk("brk_m01FD", 32'(mem['h01FD]), 'h80);
        chk("brk_m01FC", 32'(mem['h01FC]), 'h02);
        chk("brk_m01FB", 32'(mem['h01FB]), 'h30);
        chk("brk_wr", wr_cnt - w0, 3);

        // RTI
        poke(16'h01FB, 8'hFF); poke(16'h01FC, 8'h34); poke(16'h01FD, 8'h12);
        set_cpu(16'h0000, 8'h00, 8'hFA);
        is_rti = 1'b1;
        w0 = wr_cnt;
        run_start(cyc);
        chk("rti_lat", cyc, 5);
        chk("rti_pc", 32'(pc_out), 'h1234);
        chk("rti_p", 32'(status_out), 'hCF);
        chk("rti_sp", 32'(stack_out), 'hFD);
        chk("rti_wr", wr_cnt - w0, 0);

        // PPU vblank edge
        ppu_status = 8'h80;
        tick();
        set_cpu(16'hC000, 8'h01, 8'h00);
        w0 = wr_cnt;
        run_start(cyc);
`ifdef IRQ_PPU_NMI_EN
        chk("nmi_lat", cyc, 7);
        chk("nmi_pc", 32'(pc_out), 'hA000);
        chk("nmi_p", 32'(status_out), 'h05);
        chk("nmi_sp", 32'(stack_out), 'hFD);
        chk("nmi_m0100", 32'(mem['h0100]), 'hC0);
        chk("nmi_m01FF", 32'(mem['h01FF]), 'h00);
        chk("nmi_m01FE", 32'(mem['h01FE]), 'h21);
        chk("nmi_wr", wr_cnt - w0, 3);
        set_cpu(16'h4444, 8'h00, 8'h10);
        run_start(cyc);
        chk("nmi_cleared_lat", cyc, 1);
        chk("nmi_cleared_pc", 32'(pc_out), 'h4444);
`else
        chk("nonmi_lat", cyc, 1);
        chk("nonmi_pc", 32'(pc_out), 'hC000);
        chk("nonmi_sp", 32'(stack_out), 'h00);
        chk("nonmi_wr", wr_cnt - w0, 0);
`endif
        ppu_status = 8'h00;
        tick();

        // Soft reset outranks BRK
        set_cpu(16'h5555, 8'h20, 8'hFF);
        soft_reset = 1'b1; is_break = 1'b1;
        w0 = wr_cnt;
        run_start(cyc);
        chk("srst_lat", cyc, 4);
        chk("srst_pc", 32'(pc_out), 'h8000);
        chk("srst_sp", 32'(stack_out), 'hFC);
        chk("srst_p", 32'(status_out), 'h24);
        chk("srst_wr", wr_cnt - w0, 0);
        set_cpu(16'h2222, 8'h00, 8'h44);
        run_start(cyc);
        chk("srst_after_lat", cyc, 1);
        chk("srst_after_pc", 32'(pc_out), 'h2222);
        chk("srst_after_sp", 32'(stack_out), 'h44);

        // halt in the middle of BRK
        poke(16'h01FD, 8'h00); poke(16'h01FC, 8'h00); poke(16'h01FB, 8'h00);
        set_cpu(16'h8002, 8'h20, 8'hFD);
        is_break = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0; is_break = 1'b0;
        tick();
        chk("halt_pre_addr", 32'(bus.mem_addr), 'h01FD);
        chk("halt_pre_dout", 32'(bus.mem_data_out), 'h80);
        w0 = wr_cnt;
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_addr", 32'(bus.mem_addr), 'h01FD);
            chk("halt_wen", 32'(bus.mem_write_en), 'h1);
            chk("halt_busy", 32'(bus.busy), 'h1);
        end
        halt = 1'b0;
        busy_seen = 1'b0;
        wait_done(cyc);
        chk("halt_rest_lat", cyc, 6);
        chk("halt_pc", 32'(pc_out), 'h9000);
        chk("halt_p", 32'(status_out), 'h24);
        chk("halt_sp", 32'(stack_out), 'hFA);
        chk("halt_m01FD", 32'(mem['h01FD]), 'h80);
        chk("halt_m01FB", 32'(mem['h01FB]), 'h30);
        chk("halt_wr", wr_cnt - w0, 3);

        // rst mid-sequence
        set_cpu(16'h8002, 8'h20, 8'hFD);
        is_break = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0; is_break = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 'h0);
        chk("abort_done", 32'(bus.done), 'h0);
        chk("abort_addr", 32'(bus.mem_addr), 'h0);
        chk("abort_wen", 32'(bus.mem_write_en), 'h0);
        chk("abort_dout", 32'(bus.mem_data_out), 'h0);
        chk("abort_pc", 32'(pc_out), 'h0);
        chk("abort_p", 32'(status_out), 'h0);
        chk("abort_sp", 32'(stack_out), 'h0);
        chk("abort_idis", 32'(interrupt_disable), 'h0);
        set_cpu(16'h7777, 8'h00, 8'h55);
        run_start(cyc);
        chk("abort_after_lat", cyc, 1);
        chk("abort_after_pc", 32'(pc_out), 'h7777);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
